// File: rtl/scoreboard_button_conditioner_if.sv
// Board-side button inputs and controller-side command outputs of the scoreboard input stage.
// The board/bench drives the buttons (master); the conditioner drives the commands (slave).
interface scoreboard_button_conditioner_if;
  logic btn_one;
  logic btn_two;
  logic btn_three;
  logic btn_team;
  logic btn_pause;
  logic btn_reset_points;
  logic btn_reset_score;

  logic one_point;
  logic two_point;
  logic three_point;
  logic reset_points;
  logic reset_score;
  logic team;
  logic pause;

  modport master (
    output btn_one, btn_two, btn_three, btn_team, btn_pause,
           btn_reset_points, btn_reset_score,
    input  one_point, two_point, three_point, reset_points, reset_score,
           team, pause
  );

  modport slave (
    input  btn_one, btn_two, btn_three, btn_team, btn_pause,
           btn_reset_points, btn_reset_score,
    output one_point, two_point, three_point, reset_points, reset_score,
           team, pause
  );
endinterface

// File: rtl/scoreboard_button_conditioner.sv
// Synchronises, debounces and rise-detects seven raw board inputs, then turns them into
// arbitrated one-cycle score/reset commands and toggled team/pause levels for the controller.
module scoreboard_button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic                          clock,
  input logic                          reset,
  scoreboard_button_conditioner_if.slave bus
);

  localparam int NUM_CH = 7;
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam int CH_ONE          = 0;
  localparam int CH_TWO          = 1;
  localparam int CH_THREE        = 2;
  localparam int CH_TEAM         = 3;
  localparam int CH_PAUSE        = 4;
  localparam int CH_RESET_POINTS = 5;
  localparam int CH_RESET_SCORE  = 6;

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] rise;

  assign raw = {bus.btn_reset_score, bus.btn_reset_points, bus.btn_pause,
                bus.btn_team, bus.btn_three, bus.btn_two, bus.btn_one};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   synced;
    logic                   deb_q;
    logic                   deb_prev_q;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign rise[g] = deb_q & ~deb_prev_q;

    // NOTE: every piece of channel state is an ordinary flop (no RAM), so all of it is
    // cleared by reset; a button held through reset therefore counts as a fresh press.
    always_ff @(posedge clock) begin
      if (reset) begin
        sync_q     <= '0;
        cnt_q      <= '0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments let the chain shift by exactly one stage per edge.
        sync_q     <= {sync_q[SYNC_STAGES-2:0], raw[g]};
        deb_prev_q <= deb_q;
        if (synced == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
          deb_q <= synced;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_inc;
        end
      end
    end
  end

  logic one_q, two_q, three_q, reset_points_q, reset_score_q, team_q, pause_q;
  logic points_blocked;

  // A clear-scores command wins over any point that rises with it.
  assign points_blocked = rise[CH_RESET_POINTS];

  always_ff @(posedge clock) begin
    if (reset) begin
      one_q          <= 1'b0;
      two_q          <= 1'b0;
      three_q        <= 1'b0;
      reset_points_q <= 1'b0;
      reset_score_q  <= 1'b0;
      team_q         <= 1'b0;
      pause_q        <= 1'b0;
    end else begin
      three_q        <= rise[CH_THREE] & ~points_blocked;
      two_q          <= rise[CH_TWO] & ~rise[CH_THREE] & ~points_blocked;
      one_q          <= rise[CH_ONE] & ~rise[CH_TWO] & ~rise[CH_THREE] & ~points_blocked;
      reset_points_q <= rise[CH_RESET_POINTS];
      reset_score_q  <= rise[CH_RESET_SCORE];
      team_q         <= team_q ^ rise[CH_TEAM];
      pause_q        <= pause_q ^ rise[CH_PAUSE];
    end
  end

  assign bus.one_point    = one_q;
  assign bus.two_point    = two_q;
  assign bus.three_point  = three_q;
  assign bus.reset_points = reset_points_q;
  assign bus.reset_score  = reset_score_q;
  assign bus.team         = team_q;
  assign bus.pause        = pause_q;

endmodule

// File: tb/tb_scoreboard_button_conditioner.sv
// Directed bench for scoreboard_button_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4:
// a press driven before edge N shows its output at the 7th falling edge afterwards.
module tb_scoreboard_button_conditioner;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  int   acc_one, acc_two, acc_three, acc_rp, acc_rs;

  scoreboard_button_conditioner_if bus ();

  scoreboard_button_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  // Advance to the next falling edge and tally any command pulses seen there.
  task automatic tick();
    @(negedge clk);
    acc_one   += int'(bus.one_point);
    acc_two   += int'(bus.two_point);
    acc_three += int'(bus.three_point);
    acc_rp    += int'(bus.reset_points);
    acc_rs    += int'(bus.reset_score);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_acc();
    acc_one = 0; acc_two = 0; acc_three = 0; acc_rp = 0; acc_rs = 0;
  endtask

  initial begin
    total = 0;
    passed = 0;
    clear_acc();
    rst = 1'b1;
    bus.btn_one = 1'b0; bus.btn_two = 1'b0; bus.btn_three = 1'b0;
    bus.btn_team = 1'b0; bus.btn_pause = 1'b0;
    bus.btn_reset_points = 1'b0; bus.btn_reset_score = 1'b0;

    // Reset state
    ticks(3);
    check("reset_outputs", {25'd0, bus.one_point, bus.two_point, bus.three_point,
          bus.reset_points, bus.reset_score, bus.team, bus.pause}, 32'd0);
    rst = 1'b0;
    ticks(5);

    // 1: clean press, exact latency, single pulse, nothing on release
    clear_acc();
    bus.btn_one = 1'b1;
    ticks(6);
    check("t1_before_latency", bus.one_point, 1'b0);
    tick();
    check("t1_pulse", bus.one_point, 1'b1);
    tick();
    check("t1_pulse_one_cycle", bus.one_point, 1'b0);
    ticks(22);
    bus.btn_one = 1'b0;
    ticks(12);
    check("t1_pulse_count", acc_one, 1);
    check("t1_others_quiet", acc_two + acc_three + acc_rp + acc_rs, 0);
    check("t1_levels", {bus.team, bus.pause}, 2'b00);

    // 2: bouncing press settles into one pulse timed from the final rise
    clear_acc();
    bus.btn_two = 1'b1; ticks(2);
    bus.btn_two = 1'b0; ticks(2);
    bus.btn_two = 1'b1; ticks(2);
    bus.btn_two = 1'b0; ticks(2);
    bus.btn_two = 1'b1;
    ticks(6);
    check("t2_no_early_pulse", acc_two, 0);
    tick();
    check("t2_pulse", bus.two_point, 1'b1);
    ticks(10);
    bus.btn_two = 1'b0;
    ticks(10);
    check("t2_pulse_count", acc_two, 1);

    // 3: short glitch is discarded
    clear_acc();
    bus.btn_three = 1'b1; ticks(3);
    bus.btn_three = 1'b0; ticks(15);
    check("t3_glitch_dropped", acc_one + acc_two + acc_three + acc_rp + acc_rs, 0);

    // 4a: simultaneous one+three -> only three
    clear_acc();
    bus.btn_one = 1'b1; bus.btn_three = 1'b1;
    ticks(7);
    check("t4_three_wins", {bus.three_point, bus.two_point, bus.one_point}, 3'b100);
    ticks(5);
    bus.btn_one = 1'b0; bus.btn_three = 1'b0;
    ticks(10);
    check("t4_three_count", acc_three, 1);
    check("t4_lower_dropped", acc_one + acc_two, 0);

    // 4b: reset_points rising with them suppresses every point pulse
    clear_acc();
    bus.btn_one = 1'b1; bus.btn_three = 1'b1; bus.btn_reset_points = 1'b1;
    ticks(7);
    check("t4_rp_pulse", bus.reset_points, 1'b1);
    check("t4_rp_blocks_three", bus.three_point, 1'b0);
    ticks(5);
    bus.btn_one = 1'b0; bus.btn_three = 1'b0; bus.btn_reset_points = 1'b0;
    ticks(10);
    check("t4_rp_count", acc_rp, 1);
    check("t4_points_suppressed", acc_one + acc_two + acc_three, 0);

    // 5: team/pause toggles and reset_score independence
    bus.btn_team = 1'b1;
    ticks(6);
    check("t5_team_before", bus.team, 1'b0);
    tick();
    check("t5_team_first", bus.team, 1'b1);
    ticks(3);
    bus.btn_team = 1'b0; ticks(10);
    bus.btn_team = 1'b1; ticks(10);
    check("t5_team_second", bus.team, 1'b0);
    bus.btn_team = 1'b0; ticks(10);
    bus.btn_pause = 1'b1; ticks(10);
    check("t5_pause_set", bus.pause, 1'b1);
    bus.btn_pause = 1'b0; ticks(10);
    clear_acc();
    bus.btn_reset_score = 1'b1; ticks(10);
    bus.btn_reset_score = 1'b0; ticks(10);
    check("t5_rs_count", acc_rs, 1);
    check("t5_pause_kept", bus.pause, 1'b1);
    check("t5_team_kept", bus.team, 1'b0);

    // 6: reset during an in-progress press; held button counts as a fresh press
    clear_acc();
    bus.btn_one = 1'b1;
    ticks(3);
    rst = 1'b1;
    tick();
    check("t6_outputs_cleared", {25'd0, bus.one_point, bus.two_point, bus.three_point,
          bus.reset_points, bus.reset_score, bus.team, bus.pause}, 32'd0);
    tick();
    rst = 1'b0;
    ticks(6);
    check("t6_no_pulse_yet", acc_one, 0);
    tick();
    check("t6_pulse_after_reset", bus.one_point, 1'b1);
    ticks(3);
    bus.btn_one = 1'b0;
    ticks(10);
    check("t6_pulse_count", acc_one, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
